// File: rtl/uart_csr_bank.sv
// uart_csr_bank: host-facing register bank for the UART controller.
//
// Purpose
//   Holds the staged and active frame/divisor configuration, the control
//   register, the sticky interrupt status/enable pair and the FIFO data
//   port. New frame/divisor settings are applied by a small commit FSM
//   only once both datapaths report idle.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   addr_i, wr_i, rd_i        register select and single-cycle host strobes
//   wdata_i                   host write data
//   rdata_o, rd_valid_o       registered read return (latency 1)
//   tx_idle_i, rx_idle_i      datapath idle flags gating a commit
//   evt_i                     {OVR,PAR,FRM,RXRDY,TXDONE} event pulses
//   tx_full_i, rx_empty_i     FIFO flags; rx_data_i is the RX FIFO head
//   tx_data_o, tx_push_o      TX FIFO write port (registered)
//   rx_pop_o                  RX FIFO pop (combinational)
//   frame_o, divisor_o        active {DWID,PMID,SBID} and baud divisor
//   commit_o                  one-cycle pulse when staged config goes live
//   tx_en_o, rx_en_o          CTR.COM enables; rx_thr_o RX threshold
//   irq_o                     registered |(ISR & IER)
module uart_csr_bank #(
  parameter int               DATA_W     = 8,
  parameter int               DIV_W      = 16,
  parameter int               FIFO_DEPTH = 64,
  parameter logic [DIV_W-1:0] STD_DIV    = DIV_W'(54),
  parameter logic [5:0]       STD_FRAME  = 6'h0C,
  localparam int              THR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [2:0]        addr_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rd_valid_o,
  input  logic              tx_idle_i,
  input  logic              rx_idle_i,
  input  logic [4:0]        evt_i,
  input  logic              tx_full_i,
  input  logic              rx_empty_i,
  input  logic [7:0]        rx_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_push_o,
  output logic              rx_pop_o,
  output logic [5:0]        frame_o,
  output logic [DIV_W-1:0]  divisor_o,
  output logic              commit_o,
  output logic              tx_en_o,
  output logic              rx_en_o,
  output logic [THR_W-1:0]  rx_thr_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_APPLY} state_t;

  state_t             state_q, state_d;
  logic [5:0]         stg_frame_q, stg_frame_d, act_frame_q, act_frame_d;
  logic [DIV_W-1:0]   stg_div_q, stg_div_d, act_div_q, act_div_d;
  logic [1:0]         com_q, com_d;
  logic [THR_W-1:0]   thr_q, thr_d;
  logic [7:0]         ier_q, ier_d, isr_q, isr_d;
  logic               stdc_q, stdc_d;
  logic               commit_q, commit_d;
  logic               irq_q, irq_d;
  logic               tx_push_q, tx_push_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [7:0]          isr_set, isr_clr;
  logic                cfg_start;
  logic                rd_en;
  // Staged divisor widened to two host words so DVL/DVU map onto fixed slices.
  logic [2*DATA_W-1:0] div_wide, div_wide_n;

  // A simultaneous write wins; the read (and its FIFO pop) is dropped so no
  // RX byte is consumed without being returned.
  assign rd_en    = rd_i & ~wr_i;
  assign rx_pop_o = rd_en && (addr_i == 3'd7) && !rx_empty_i;

  always_comb begin
    state_d     = state_q;
    stg_frame_d = stg_frame_q;
    act_frame_d = act_frame_q;
    act_div_d   = act_div_q;
    com_d       = com_q;
    thr_d       = thr_q;
    ier_d       = ier_q;
    stdc_d      = 1'b0;
    commit_d    = 1'b0;
    tx_push_d   = 1'b0;
    tx_data_d   = tx_data_q;
    rd_valid_d  = 1'b0;
    rdata_d     = rdata_q;
    isr_set     = {3'b000, evt_i};
    isr_clr     = 8'h00;
    cfg_start   = 1'b0;
    div_wide    = '0;
    div_wide[DIV_W-1:0] = stg_div_q;
    div_wide_n  = div_wide;

    if (wr_i) begin
      case (addr_i)
        3'd0: begin
          stg_frame_d = wdata_i[5:0];
          cfg_start   = 1'b1;
        end
        3'd1: div_wide_n[DATA_W-1:0] = wdata_i;
        3'd2: begin
          div_wide_n[2*DATA_W-1:DATA_W] = wdata_i;
          cfg_start = 1'b1;
        end
        3'd3: thr_d = wdata_i[THR_W-1:0];
        3'd4: begin
          com_d  = wdata_i[4:3];
          stdc_d = wdata_i[0];
        end
        3'd5: isr_clr = wdata_i[7:0];
        3'd6: ier_d   = wdata_i[7:0];
        default: begin
          if (tx_full_i) begin
            isr_set[6] = 1'b1;
          end else begin
            tx_push_d = 1'b1;
            tx_data_d = wdata_i[7:0];
          end
        end
      endcase
    end
    stg_div_d = div_wide_n[DIV_W-1:0];

    if (rd_en) begin
      rd_valid_d = 1'b1;
      case (addr_i)
        3'd0: rdata_d = DATA_W'(stg_frame_q);
        3'd1: rdata_d = div_wide[DATA_W-1:0];
        3'd2: rdata_d = div_wide[2*DATA_W-1:DATA_W];
        3'd3: rdata_d = DATA_W'({tx_full_i, rx_empty_i, thr_q});
        3'd4: rdata_d = DATA_W'({com_q, 3'b000});
        3'd5: rdata_d = DATA_W'(isr_q);
        3'd6: rdata_d = DATA_W'(ier_q);
        default: begin
          if (rx_empty_i) begin
            rdata_d    = '0;
            isr_set[7] = 1'b1;
          end else begin
            rdata_d = DATA_W'(rx_data_i);
          end
        end
      endcase
    end

    case (state_q)
      S_IDLE:  if (cfg_start) state_d = S_PEND;
      S_PEND:  state_d = S_WAIT;
      S_WAIT: begin
        if (tx_idle_i && rx_idle_i) begin
          state_d = S_APPLY;
          // Use the next staged values so a write in this very cycle is applied.
          act_frame_d = stg_frame_d;
          act_div_d   = stg_div_d;
          commit_d    = 1'b1;
          isr_set[5]  = 1'b1;
        end
      end
      default: state_d = cfg_start ? S_PEND : S_IDLE;
    endcase

    // Standard-config one cycle after the STDC write overrides everything above.
    if (stdc_q) begin
      stg_frame_d = STD_FRAME;
      stg_div_d   = STD_DIV;
      act_frame_d = STD_FRAME;
      act_div_d   = STD_DIV;
      state_d     = S_IDLE;
      commit_d    = 1'b0;
      isr_set[5]  = 1'b0;
    end

    // Set beats clear when both hit the same bit.
    isr_d = (isr_q & ~isr_clr) | isr_set;
    irq_d = |(isr_d & ier_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      stg_frame_q <= STD_FRAME;
      act_frame_q <= STD_FRAME;
      stg_div_q   <= STD_DIV;
      act_div_q   <= STD_DIV;
      com_q       <= 2'b11;
      thr_q       <= '0;
      ier_q       <= 8'h00;
      isr_q       <= 8'h00;
      stdc_q      <= 1'b0;
      commit_q    <= 1'b0;
      irq_q       <= 1'b0;
      tx_push_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      stg_frame_q <= stg_frame_d;
      act_frame_q <= act_frame_d;
      stg_div_q   <= stg_div_d;
      act_div_q   <= act_div_d;
      com_q       <= com_d;
      thr_q       <= thr_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      stdc_q      <= stdc_d;
      commit_q    <= commit_d;
      irq_q       <= irq_d;
      tx_push_q   <= tx_push_d;
      tx_data_q   <= tx_data_d;
      rd_valid_q  <= rd_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rd_valid_o = rd_valid_q;
  assign tx_data_o  = tx_data_q;
  assign tx_push_o  = tx_push_q;
  assign frame_o    = act_frame_q;
  assign divisor_o  = act_div_q;
  assign commit_o   = commit_q;
  assign tx_en_o    = com_q[0];
  assign rx_en_o    = com_q[1];
  assign rx_thr_o   = thr_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_uart_csr_bank.sv
// tb_uart_csr_bank: directed scenarios followed by random traffic, all
// compared each cycle against a cycle-level behavioural model of the bank.
module tb_uart_csr_bank;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [2:0]  addr_i;
  logic        wr_i, rd_i;
  logic [7:0]  wdata_i;
  logic [7:0]  rdata_o;
  logic        rd_valid_o;
  logic        tx_idle_i, rx_idle_i;
  logic [4:0]  evt_i;
  logic        tx_full_i, rx_empty_i;
  logic [7:0]  rx_data_i;
  logic [7:0]  tx_data_o;
  logic        tx_push_o, rx_pop_o;
  logic [5:0]  frame_o;
  logic [15:0] divisor_o;
  logic        commit_o, tx_en_o, rx_en_o;
  logic [5:0]  rx_thr_o;
  logic        irq_o;

  uart_csr_bank dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i), .wr_i(wr_i), .rd_i(rd_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rd_valid_o(rd_valid_o),
    .tx_idle_i(tx_idle_i), .rx_idle_i(rx_idle_i), .evt_i(evt_i),
    .tx_full_i(tx_full_i), .rx_empty_i(rx_empty_i), .rx_data_i(rx_data_i),
    .tx_data_o(tx_data_o), .tx_push_o(tx_push_o), .rx_pop_o(rx_pop_o),
    .frame_o(frame_o), .divisor_o(divisor_o), .commit_o(commit_o),
    .tx_en_o(tx_en_o), .rx_en_o(rx_en_o), .rx_thr_o(rx_thr_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [5:0]  m_sframe, m_frame, m_thr;
  bit [15:0] m_sdiv, m_div;
  bit [1:0]  m_com;
  bit [7:0]  m_ier, m_isr;
  bit        m_pend;      // a config change is waiting to go live
  int        m_age;       // cycles since the write that started it
  bit        m_stdc;      // standard-config requested last cycle
  bit        e_commit, e_push, e_rdv, e_irq;
  bit [7:0]  e_rdata, e_txdata;

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit [7:0] set, clr;
    bit trig, was_pend, rdo;
    if (!rst_n_i) begin
      m_sframe = 6'h0C; m_frame = 6'h0C; m_sdiv = 16'd54; m_div = 16'd54;
      m_com = 2'b11; m_thr = 0; m_ier = 0; m_isr = 0;
      m_pend = 0; m_age = 0; m_stdc = 0;
      e_commit = 0; e_push = 0; e_rdv = 0; e_irq = 0; e_rdata = 0; e_txdata = 0;
      return;
    end
    set = {3'b000, evt_i}; clr = 0; trig = 0;
    rdo = rd_i && !wr_i;
    e_rdv = rdo; e_push = 0; e_commit = 0;
    if (rdo) begin
      case (addr_i)
        3'd0: e_rdata = {2'b00, m_sframe};
        3'd1: e_rdata = m_sdiv[7:0];
        3'd2: e_rdata = m_sdiv[15:8];
        3'd3: e_rdata = {tx_full_i, rx_empty_i, m_thr};
        3'd4: e_rdata = {3'b000, m_com, 3'b000};
        3'd5: e_rdata = m_isr;
        3'd6: e_rdata = m_ier;
        default: begin
          e_rdata = rx_empty_i ? 8'h00 : rx_data_i;
          if (rx_empty_i) set[7] = 1;
        end
      endcase
    end
    if (wr_i) begin
      case (addr_i)
        3'd0: begin m_sframe = wdata_i[5:0]; trig = 1; end
        3'd1: m_sdiv[7:0] = wdata_i;
        3'd2: begin m_sdiv[15:8] = wdata_i; trig = 1; end
        3'd3: m_thr = wdata_i[5:0];
        3'd4: m_com = wdata_i[4:3];
        3'd5: clr = wdata_i;
        3'd6: m_ier = wdata_i;
        default: begin
          if (tx_full_i) set[6] = 1;
          else begin e_push = 1; e_txdata = wdata_i; end
        end
      endcase
    end
    // A change goes live on the first cycle, two or more after the
    // starting write, in which both datapaths are idle.
    was_pend = m_pend;
    if (m_pend) m_age++;
    if (was_pend && m_age >= 2 && tx_idle_i && rx_idle_i) begin
      m_frame = m_sframe; m_div = m_sdiv; e_commit = 1; set[5] = 1; m_pend = 0;
    end else if (trig && !was_pend) begin
      m_pend = 1; m_age = 0;
    end
    if (m_stdc) begin
      m_sframe = 6'h0C; m_frame = 6'h0C; m_sdiv = 16'd54; m_div = 16'd54;
      m_pend = 0; e_commit = 0; set[5] = 0;
    end
    m_stdc = wr_i && addr_i == 3'd4 && wdata_i[0];
    m_isr = (m_isr & ~clr) | set;
    e_irq = |(m_isr & m_ier);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      chk("frame_o", frame_o, m_frame);
      chk("divisor_o", divisor_o, m_div);
      chk("commit_o", commit_o, e_commit);
      chk("tx_en_o", tx_en_o, m_com[0]);
      chk("rx_en_o", rx_en_o, m_com[1]);
      chk("rx_thr_o", rx_thr_o, m_thr);
      chk("irq_o", irq_o, e_irq);
      chk("rd_valid_o", rd_valid_o, e_rdv);
      if (e_rdv) chk("rdata_o", rdata_o, e_rdata);
      chk("tx_push_o", tx_push_o, e_push);
      if (e_push) chk("tx_data_o", tx_data_o, e_txdata);
      chk("rx_pop_o", rx_pop_o, rd_i && !wr_i && addr_i == 3'd7 && !rx_empty_i);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    addr_i = a; wdata_i = d; wr_i = 1; rd_i = 0;
    step();
    wr_i = 0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    addr_i = a; rd_i = 1; wr_i = 0;
    step();
    rd_i = 0;
    chk("rd_valid_latency", rd_valid_o, 1'b1);
    d = rdata_o;
  endtask

  task automatic run_cnt(input int n, output int c);
    c = 0;
    repeat (n) begin
      step();
      if (commit_o) c++;
    end
  endtask

  logic [7:0] d;
  int c;

  initial begin
    rst_n_i = 0; addr_i = 0; wr_i = 0; rd_i = 0; wdata_i = 0;
    tx_idle_i = 1; rx_idle_i = 1; evt_i = 0; tx_full_i = 0; rx_empty_i = 0;
    rx_data_i = 0;
    step(); step(); step();
    rst_n_i = 1;

    // Reset state
    chk("rst_frame", frame_o, 6'h0C);
    chk("rst_div", divisor_o, 16'd54);
    chk("rst_irq", irq_o, 1'b0);
    rd_reg(3'd0, d); chk("rst_STR", d, 8'h0C);
    rd_reg(3'd1, d); chk("rst_DVL", d, 8'h36);
    rd_reg(3'd2, d); chk("rst_DVU", d, 8'h00);
    rd_reg(3'd5, d); chk("rst_ISR", d, 8'h00);

    // Commit held off while TX busy
    tx_idle_i = 0;
    wr_reg(3'd1, 8'h10);
    wr_reg(3'd2, 8'h01);
    run_cnt(20, c);
    chk("busy_div", divisor_o, 16'd54);
    chk("busy_commits", c, 0);
    tx_idle_i = 1;
    run_cnt(6, c);
    chk("idle_div", divisor_o, 16'h0110);
    chk("idle_commits", c, 1);
    wr_reg(3'd5, 8'hFF);

    // Interrupt set / clear / set-beats-clear
    wr_reg(3'd6, 8'h04);
    evt_i = 5'b00100; step(); evt_i = 0;
    chk("irq_set", irq_o, 1'b1);
    wr_reg(3'd5, 8'h04);
    chk("irq_clr", irq_o, 1'b0);
    evt_i = 5'b00100; addr_i = 3'd5; wdata_i = 8'h04; wr_i = 1;
    step(); wr_i = 0; evt_i = 0;
    chk("irq_set_beats_clr", irq_o, 1'b1);
    rd_reg(3'd5, d); chk("isr_frm", d, 8'h04);
    wr_reg(3'd5, 8'hFF);

    // TX data port
    tx_full_i = 1;
    wr_reg(3'd7, 8'hA5);
    chk("full_no_push", tx_push_o, 1'b0);
    rd_reg(3'd5, d); chk("isr_txovf", d[6], 1'b1);
    tx_full_i = 0;
    wr_reg(3'd7, 8'hA5);
    chk("push", tx_push_o, 1'b1);
    chk("push_data", tx_data_o, 8'hA5);
    wr_reg(3'd5, 8'hFF);

    // RX data port
    rx_empty_i = 1; addr_i = 3'd7; rd_i = 1; #1;
    chk("empty_no_pop", rx_pop_o, 1'b0);
    step(); rd_i = 0;
    chk("empty_rdata", rdata_o, 8'h00);
    rd_reg(3'd5, d); chk("isr_rxund", d[7], 1'b1);
    rx_empty_i = 0; rx_data_i = 8'h3C; addr_i = 3'd7; rd_i = 1; #1;
    chk("pop", rx_pop_o, 1'b1);
    step(); rd_i = 0;
    chk("rx_rdata", rdata_o, 8'h3C);
    wr_reg(3'd5, 8'hFF);

    // Standard-config while waiting for idle
    tx_idle_i = 0;
    wr_reg(3'd0, 8'h2F);
    step();
    wr_reg(3'd4, 8'h19);
    tx_idle_i = 1;
    run_cnt(10, c);
    chk("stdc_commits", c, 0);
    chk("stdc_frame", frame_o, 6'h0C);
    chk("stdc_div", divisor_o, 16'd54);
    rd_reg(3'd4, d); chk("ctr_readback", d, 8'h18);
    rd_reg(3'd0, d); chk("stdc_STR", d, 8'h0C);

    // Reset in the middle of a commit
    wr_reg(3'd0, 8'h2F);
    run_cnt(6, c);
    chk("frame_2f", frame_o, 6'h2F);
    tx_idle_i = 0;
    wr_reg(3'd0, 8'h15);
    #2 rst_n_i = 0;
    #1 chk("async_rst_frame", frame_o, 6'h0C);
    step(); step();
    rst_n_i = 1; tx_idle_i = 1;
    run_cnt(6, c);
    chk("rst_lost_commits", c, 0);
    rd_reg(3'd0, d); chk("rst_lost_STR", d, 8'h0C);

    // Random traffic
    repeat (3000) begin
      wr_i       = ($urandom_range(3) == 0);
      rd_i       = ($urandom_range(2) == 0);
      addr_i     = 3'($urandom_range(7));
      wdata_i    = 8'($urandom);
      if (addr_i == 3'd4 && $urandom_range(3) != 0) wdata_i[0] = 1'b0;
      tx_idle_i  = ($urandom_range(3) != 0);
      rx_idle_i  = ($urandom_range(3) != 0);
      evt_i      = ($urandom_range(7) == 0) ? 5'($urandom) : 5'd0;
      tx_full_i  = ($urandom_range(3) == 0);
      rx_empty_i = ($urandom_range(3) == 0);
      rx_data_i  = 8'($urandom);
      step();
    end
    wr_i = 0; rd_i = 0; evt_i = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
